// File: rtl/irq_controller_if.sv
// Fetch-side handshake between irq_controller and the fetch/decode stages.
// master = controller side, slave = fetch side.
interface irq_controller_if;
   logic        irq_req;
   logic        irq_active;
   logic [1:0]  irq_src;
   logic [31:0] rdi_data;
   logic        irq_ack;
   logic        rti_in;

   modport master (
      output irq_req, irq_active, irq_src, rdi_data,
      input  irq_ack, rti_in
   );

   modport slave (
      input  irq_req, irq_active, irq_src, rdi_data,
      output irq_ack, rti_in
   );
endinterface

// File: rtl/irq_controller.sv
// Two-source edge-triggered interrupt controller (key, eth; eth wins).
// Define IRQ_SYNC_EN to put a 2-flop synchronizer on each irq input.
module irq_controller (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        irq_key_in,
   input  logic        irq_eth_in,
   input  logic [31:0] key_data_in,
   input  logic [31:0] eth_data_in,
   input  logic        irq_en,
   output logic [7:0]  drop_cnt,
   irq_controller_if.master fetch
);

   typedef enum logic [2:0] {
      IDLE    = 3'b001,
      REQ     = 3'b010,
      SERVICE = 3'b100
   } state_t;

   logic        key_s;
   logic        eth_s;

`ifdef IRQ_SYNC_EN
   logic [1:0]  key_sync;
   logic [1:0]  eth_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_sync <= 2'b00;
         eth_sync <= 2'b00;
      end else begin
         key_sync <= {key_sync[0], irq_key_in};
         eth_sync <= {eth_sync[0], irq_eth_in};
      end
   end

   assign key_s = key_sync[1];
   assign eth_s = eth_sync[1];
`else
   assign key_s = irq_key_in;
   assign eth_s = irq_eth_in;
`endif

   // Bit 0 = key, bit 1 = eth; irq_src uses the same one-hot code.
   logic [1:0]  cur;
   logic [1:0]  prev;
   logic [1:0]  edg;
   logic [1:0]  pend;
   logic [1:0]  pend_nxt;
   logic [1:0]  clr;
   logic [1:0]  drop;
   logic [1:0]  cap;
   logic [8:0]  drop_sum;
   logic [31:0] key_buf;
   logic [31:0] eth_buf;

   state_t      state;
   state_t      state_nxt;
   logic        grant_ld;
   logic        src_clr;
   logic [1:0]  gsel;
   logic [1:0]  gsrc;
   logic [31:0] gdata;

   assign cur  = {eth_s, key_s};
   assign edg  = cur & ~prev;
   assign clr  = (state == REQ && fetch.irq_ack) ? gsrc : 2'b00;
   assign drop = edg & pend & ~clr;
   assign cap  = edg & ~drop;

   // An edge landing on its own ack clear keeps the bit pending.
   assign pend_nxt = (pend & ~clr) | edg;

   assign drop_sum = {1'b0, drop_cnt}
                   + {8'd0, drop[0]}
                   + {8'd0, drop[1]};

   assign gsel = pend[1] ? 2'b10 : 2'b01;

   always_comb begin
      state_nxt = state;
      grant_ld  = 1'b0;
      src_clr   = 1'b0;
      unique case (state)
         IDLE: begin
            if (irq_en && (|pend)) begin
               state_nxt = REQ;
               grant_ld  = 1'b1;
            end
         end
         REQ: begin
            if (fetch.irq_ack) begin
               state_nxt = SERVICE;
            end else if (!irq_en) begin
               state_nxt = IDLE;
               src_clr   = 1'b1;
            end
         end
         SERVICE: begin
            if (fetch.rti_in) begin
               state_nxt = IDLE;
               src_clr   = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            src_clr   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev     <= 2'b00;
         pend     <= 2'b00;
         key_buf  <= 32'd0;
         eth_buf  <= 32'd0;
         drop_cnt <= 8'd0;
         state    <= IDLE;
         gsrc     <= 2'b00;
         gdata    <= 32'd0;
      end else begin
         prev     <= cur;
         pend     <= pend_nxt;
         drop_cnt <= drop_sum[8] ? 8'hff : drop_sum[7:0];
         state    <= state_nxt;
         if (cap[0]) key_buf <= key_data_in;
         if (cap[1]) eth_buf <= eth_data_in;
         if (grant_ld) begin
            gsrc  <= gsel;
            gdata <= pend[1] ? eth_buf : key_buf;
         end else if (src_clr) begin
            gsrc  <= 2'b00;
         end
      end
   end

   assign fetch.irq_req    = (state == REQ);
   assign fetch.irq_active = (state == SERVICE);
   assign fetch.irq_src    = gsrc;
   assign fetch.rdi_data   = gdata;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: per-cycle reference model plus directed scenarios.
// Latency expectations follow IRQ_SYNC_EN when it is defined.
module tb_irq_controller;

`ifdef IRQ_SYNC_EN
   localparam int SD = 2;
`else
   localparam int SD = 0;
`endif
   localparam int LAT = 2 + SD;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        irq_key_in = 1'b0;
   logic        irq_eth_in = 1'b0;
   logic [31:0] key_data_in = '0;
   logic [31:0] eth_data_in = '0;
   logic        irq_en = 1'b0;
   logic [7:0]  drop_cnt;

   irq_controller_if fif ();

   irq_controller dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .irq_key_in  (irq_key_in),
      .irq_eth_in  (irq_eth_in),
      .key_data_in (key_data_in),
      .eth_data_in (eth_data_in),
      .irq_en      (irq_en),
      .drop_cnt    (drop_cnt),
      .fetch       (fif)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit run = 1'b0;

   function automatic void chk(string nm, logic [31:0] act,
                               logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endfunction

   // Reference model: mode 0 idle, 1 requesting, 2 in service.
   bit [1:0]  ms1, ms2, mprev, mpend, mraw, meff, medge, mclr;
   bit [31:0] mbuf [2];
   bit [31:0] mdat [2];
   bit [31:0] mrdi;
   bit [1:0]  msrc;
   int        mdrop, mmode, mg;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ms1 = 0; ms2 = 0; mprev = 0; mpend = 0;
         mbuf[0] = 0; mbuf[1] = 0; mrdi = 0; msrc = 0;
         mdrop = 0; mmode = 0; mg = 0;
      end else begin
         mraw = {irq_eth_in, irq_key_in};
         if (SD > 0) begin
            meff = ms2; ms2 = ms1; ms1 = mraw;
         end else begin
            meff = mraw;
         end
         medge = meff & ~mprev;
         mprev = meff;
         mclr = 0;
         if (mmode == 1 && fif.irq_ack) mclr[mg] = 1'b1;
         mdat[0] = key_data_in;
         mdat[1] = eth_data_in;
         case (mmode)
            0: if (irq_en && mpend != 0) begin
                  mg = mpend[1] ? 1 : 0;
                  msrc = (mg == 1) ? 2'b10 : 2'b01;
                  mrdi = mbuf[mg];
                  mmode = 1;
               end
            1: if (fif.irq_ack) mmode = 2;
               else if (!irq_en) begin mmode = 0; msrc = 0; end
            default: if (fif.rti_in) begin mmode = 0; msrc = 0; end
         endcase
         for (int s = 0; s < 2; s++) begin
            if (medge[s]) begin
               if (mpend[s] && !mclr[s]) begin
                  if (mdrop < 255) mdrop++;
               end else begin
                  mpend[s] = 1'b1;
                  mbuf[s] = mdat[s];
               end
            end else if (mclr[s]) begin
               mpend[s] = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (run) begin
         chk("m_irq_req", {31'd0, fif.irq_req}, {31'd0, mmode == 1});
         chk("m_irq_active", {31'd0, fif.irq_active},
             {31'd0, mmode == 2});
         chk("m_irq_src", {30'd0, fif.irq_src}, {30'd0, msrc});
         chk("m_drop_cnt", {24'd0, drop_cnt}, mdrop);
         if (mmode != 0 || !rst_n)
            chk("m_rdi_data", fif.rdi_data, mrdi);
      end
   end

   task automatic step(int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_req(string nm);
      int n = 0;
      while (!fif.irq_req && n < 12) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!fif.irq_req) begin
         errors++;
         $display("FAIL %s got=irq_req 0 exp=irq_req 1", nm);
      end
   endtask

   initial begin
      fif.irq_ack = 1'b0;
      fif.rti_in  = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      step(1);
      run = 1'b1;
      step(2);
      chk("rst_req", {31'd0, fif.irq_req}, 0);
      chk("rst_src", {30'd0, fif.irq_src}, 0);
      chk("rst_drop", {24'd0, drop_cnt}, 0);
      rst_n = 1'b1;
      irq_en = 1'b1;
      step(2);

      // single key request, latency
      key_data_in = 32'h0000_00A5;
      irq_key_in = 1'b1;
      step(LAT - 1);
      chk("k_req_early", {31'd0, fif.irq_req}, 0);
      step(1);
      chk("k_req", {31'd0, fif.irq_req}, 1);
      chk("k_src", {30'd0, fif.irq_src}, 2'b01);
      chk("k_rdi", fif.rdi_data, 32'h0000_00A5);
      irq_key_in = 1'b0;
      fif.irq_ack = 1'b1;
      step(1);
      fif.irq_ack = 1'b0;
      chk("k_act", {31'd0, fif.irq_active}, 1);
      chk("k_req_off", {31'd0, fif.irq_req}, 0);
      fif.rti_in = 1'b1;
      step(1);
      fif.rti_in = 1'b0;
      chk("k_rti_act", {31'd0, fif.irq_active}, 0);
      chk("k_rti_src", {30'd0, fif.irq_src}, 0);
      step(3);

      // simultaneous edges: eth first, then key
      key_data_in = 32'h0000_0011;
      eth_data_in = 32'h1234_5678;
      irq_key_in = 1'b1;
      irq_eth_in = 1'b1;
      step(LAT);
      chk("both_src", {30'd0, fif.irq_src}, 2'b10);
      chk("both_rdi", fif.rdi_data, 32'h1234_5678);
      irq_key_in = 1'b0;
      irq_eth_in = 1'b0;
      fif.irq_ack = 1'b1;
      step(1);
      fif.irq_ack = 1'b0;
      fif.rti_in = 1'b1;
      step(1);
      fif.rti_in = 1'b0;
      chk("both_idle", {31'd0, fif.irq_req}, 0);
      step(1);
      chk("both_key_req", {31'd0, fif.irq_req}, 1);
      chk("both_key_src", {30'd0, fif.irq_src}, 2'b01);
      chk("both_key_rdi", fif.rdi_data, 32'h0000_0011);
      fif.irq_ack = 1'b1;
      step(1);
      fif.irq_ack = 1'b0;
      fif.rti_in = 1'b1;
      step(1);
      fif.rti_in = 1'b0;
      step(3);

      // repeated eth edges while pending
      eth_data_in = 32'hE1; irq_eth_in = 1'b1; step(1);
      irq_eth_in = 1'b0; step(1);
      eth_data_in = 32'hE2; irq_eth_in = 1'b1; step(1);
      irq_eth_in = 1'b0; step(1);
      eth_data_in = 32'hE3; irq_eth_in = 1'b1; step(1);
      irq_eth_in = 1'b0;
      step(SD + 1);
      chk("drop2", {24'd0, drop_cnt}, 2);
      chk("drop_rdi", fif.rdi_data, 32'hE1);
      chk("drop_src", {30'd0, fif.irq_src}, 2'b10);

      // new edge together with ack
      eth_data_in = 32'hE4;
      irq_eth_in = 1'b1;
      fif.irq_ack = 1'b1;
      step(1);
      fif.irq_ack = 1'b0;
      irq_eth_in = 1'b0;
      chk("coin_act", {31'd0, fif.irq_active}, 1);
      chk("coin_rdi", fif.rdi_data, 32'hE1);
      fif.rti_in = 1'b1;
      step(1);
      fif.rti_in = 1'b0;
      wait_req("coin_wait");
      chk("coin_src", {30'd0, fif.irq_src}, 2'b10);
      chk("coin_rdi2", fif.rdi_data, 32'hE4);

      // enable withdrawn during request
      irq_en = 1'b0;
      step(1);
      chk("en0_req", {31'd0, fif.irq_req}, 0);
      chk("en0_src", {30'd0, fif.irq_src}, 0);
      step(1);
      chk("en0_hold", {31'd0, fif.irq_req}, 0);
      irq_en = 1'b1;
      step(1);
      chk("en1_req", {31'd0, fif.irq_req}, 1);
      chk("en1_rdi", fif.rdi_data, 32'hE4);
      fif.irq_ack = 1'b1;
      step(1);
      fif.irq_ack = 1'b0;
      chk("en1_act", {31'd0, fif.irq_active}, 1);

      // async reset in service
      #2 rst_n = 1'b0;
      #1;
      chk("ar_act", {31'd0, fif.irq_active}, 0);
      chk("ar_req", {31'd0, fif.irq_req}, 0);
      chk("ar_src", {30'd0, fif.irq_src}, 0);
      chk("ar_rdi", fif.rdi_data, 0);
      chk("ar_drop", {24'd0, drop_cnt}, 0);
      step(1);
      rst_n = 1'b1;
      step(6);
      chk("ar_no_req", {31'd0, fif.irq_req}, 0);
      key_data_in = 32'h0000_005A;
      irq_key_in = 1'b1;
      wait_req("ar_wait");
      irq_key_in = 1'b0;
      chk("ar_key_src", {30'd0, fif.irq_src}, 2'b01);
      chk("ar_key_rdi", fif.rdi_data, 32'h0000_005A);

      // drop counter saturation
      repeat (260) begin
         irq_eth_in = 1'b1; step(1);
         irq_eth_in = 1'b0; step(1);
      end
      step(SD + 1);
      chk("sat_drop", {24'd0, drop_cnt}, 255);
      chk("sat_src", {30'd0, fif.irq_src}, 2'b01);
      fif.irq_ack = 1'b1;
      step(1);
      fif.irq_ack = 1'b0;
      fif.rti_in = 1'b1;
      step(1);
      fif.rti_in = 1'b0;
      wait_req("sat_wait");
      chk("sat_eth_src", {30'd0, fif.irq_src}, 2'b10);
      step(2);

      run = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
